// File: rtl/ddr_port_arbiter_if.sv
// rtl/ddr_port_arbiter_if.sv - request/write/response/read channel bundle for one DDR port
interface ddr_port_arbiter_if #(
    parameter int ADDR_W = 27
);
    logic              arw_valid;
    logic              arw_ready;
    logic [ADDR_W-1:0] arw_addr;
    logic [7:0]        arw_len;
    logic              arw_write;
    logic              wvalid;
    logic              wready;
    logic              wlast;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              bvalid;
    logic              bready;
    logic              rvalid;
    logic              rready;
    logic              rlast;
    logic [31:0]       rdata;

    modport master (
        output arw_valid, arw_addr, arw_len, arw_write,
        output wvalid, wlast, wdata, wstrb, bready, rready,
        input  arw_ready, wready, bvalid, rvalid, rlast, rdata
    );

    modport slave (
        input  arw_valid, arw_addr, arw_len, arw_write,
        input  wvalid, wlast, wdata, wstrb, bready, rready,
        output arw_ready, wready, bvalid, rvalid, rlast, rdata
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - three-port round-robin arbiter, one DDR transaction outstanding
module ddr_port_arbiter #(
    parameter int ADDR_W = 27
) (
    input  logic               clk,
    input  logic               reset,
    ddr_port_arbiter_if.slave  m0,
    ddr_port_arbiter_if.slave  m1,
    ddr_port_arbiter_if.slave  m2,
    ddr_port_arbiter_if.master s,
    output logic [1:0]         s_arw_id,
    input  logic [1:0]         s_bid,
    input  logic [1:0]         s_rid,
    output logic               id_err
);
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA} state_t;

    state_t            state, state_next;
    logic [1:0]        last_grant, idx, win, cand;
    logic              win_valid;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q, beat_cnt;
    logic              write_q;

    logic [2:0]        req_v, wvalid_v, wlast_v, bready_v, rready_v, write_a;
    logic [ADDR_W-1:0] addr_a [3];
    logic [7:0]        len_a [3];
    logic [31:0]       wdata_a [3];
    logic [3:0]        wstrb_a [3];

    logic [2:0]        arw_ready_v, wready_v, bvalid_v, rvalid_v, rlast_v;
    logic              s_wvalid_c, s_wlast_c, s_bready_c, s_rready_c, w_hs;

    assign req_v    = {m2.arw_valid, m1.arw_valid, m0.arw_valid};
    assign write_a  = {m2.arw_write, m1.arw_write, m0.arw_write};
    assign wvalid_v = {m2.wvalid, m1.wvalid, m0.wvalid};
    assign wlast_v  = {m2.wlast, m1.wlast, m0.wlast};
    assign bready_v = {m2.bready, m1.bready, m0.bready};
    assign rready_v = {m2.rready, m1.rready, m0.rready};
    assign addr_a   = '{m0.arw_addr, m1.arw_addr, m2.arw_addr};
    assign len_a    = '{m0.arw_len, m1.arw_len, m2.arw_len};
    assign wdata_a  = '{m0.wdata, m1.wdata, m2.wdata};
    assign wstrb_a  = '{m0.wstrb, m1.wstrb, m2.wstrb};

    function automatic logic [1:0] rr_port(input logic [1:0] base, input logic [1:0] k);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, k};
        if (sum >= 3'd3) sum = sum - 3'd3;
        return sum[1:0];
    endfunction

    // Search starts just after the last winner, so that port ends up last.
    always_comb begin
        win_valid = 1'b0;
        win       = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            cand = rr_port(last_grant, 2'(k));
            if (!win_valid && req_v[cand]) begin
                win_valid = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        state_next  = state;
        arw_ready_v = '0;
        wready_v    = '0;
        bvalid_v    = '0;
        rvalid_v    = '0;
        rlast_v     = '0;
        s_wvalid_c  = 1'b0;
        s_wlast_c   = 1'b0;
        s_bready_c  = 1'b0;
        s_rready_c  = 1'b0;
        w_hs        = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    arw_ready_v[win] = 1'b1;
                    state_next       = ADDR;
                end
            end
            ADDR: begin
                if (s.arw_ready) state_next = write_q ? WDATA : RDATA;
            end
            WDATA: begin
                s_wvalid_c    = wvalid_v[idx];
                s_wlast_c     = wlast_v[idx];
                wready_v[idx] = s.wready;
                w_hs          = s_wvalid_c && s.wready;
                if (w_hs && (beat_cnt == len_q || s_wlast_c)) state_next = WRESP;
            end
            WRESP: begin
                bvalid_v[idx] = s.bvalid;
                s_bready_c    = bready_v[idx];
                if (s.bvalid && s_bready_c) state_next = IDLE;
            end
            RDATA: begin
                rvalid_v[idx] = s.rvalid;
                rlast_v[idx]  = s.rlast;
                s_rready_c    = rready_v[idx];
                if (s.rvalid && s.rlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Handshakes are silenced for the whole reset cycle, not just after it.
        if (reset) begin
            arw_ready_v = '0;
            wready_v    = '0;
            bvalid_v    = '0;
            rvalid_v    = '0;
            rlast_v     = '0;
            s_wvalid_c  = 1'b0;
            s_bready_c  = 1'b0;
            s_rready_c  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 2'd2;
            idx        <= 2'd0;
            beat_cnt   <= 8'd0;
            addr_q     <= '0;
            len_q      <= 8'd0;
            write_q    <= 1'b0;
            id_err     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && win_valid) begin
                idx        <= win;
                last_grant <= win;
                addr_q     <= addr_a[win];
                len_q      <= len_a[win];
                write_q    <= write_a[win];
                beat_cnt   <= 8'd0;
            end
            if (w_hs) beat_cnt <= beat_cnt + 8'd1;
            if ((state == WRESP && s.bvalid && s_bid != idx) ||
                (state == RDATA && s.rvalid && s_rid != idx))
                id_err <= 1'b1;
        end
    end

    assign s.arw_valid = (state == ADDR) && !reset;
    assign s.arw_addr  = addr_q;
    assign s.arw_len   = len_q;
    assign s.arw_write = write_q;
    assign s_arw_id    = idx;
    assign s.wvalid    = s_wvalid_c;
    assign s.wlast     = s_wlast_c;
    assign s.wdata     = wdata_a[idx];
    assign s.wstrb     = wstrb_a[idx];
    assign s.bready    = s_bready_c;
    assign s.rready    = s_rready_c;

    assign m0.arw_ready = arw_ready_v[0];
    assign m1.arw_ready = arw_ready_v[1];
    assign m2.arw_ready = arw_ready_v[2];
    assign m0.wready    = wready_v[0];
    assign m1.wready    = wready_v[1];
    assign m2.wready    = wready_v[2];
    assign m0.bvalid    = bvalid_v[0];
    assign m1.bvalid    = bvalid_v[1];
    assign m2.bvalid    = bvalid_v[2];
    assign m0.rvalid    = rvalid_v[0];
    assign m1.rvalid    = rvalid_v[1];
    assign m2.rvalid    = rvalid_v[2];
    assign m0.rlast     = rlast_v[0];
    assign m1.rlast     = rlast_v[1];
    assign m2.rlast     = rlast_v[2];
    assign m0.rdata     = s.rdata;
    assign m1.rdata     = s.rdata;
    assign m2.rdata     = s.rdata;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - randomized self-checking bench for ddr_port_arbiter
module tb_ddr_port_arbiter;
    localparam int ADDR_W = 27;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ddr_port_arbiter_if #(.ADDR_W(ADDR_W)) m_if [3] ();
    ddr_port_arbiter_if #(.ADDR_W(ADDR_W)) s_if ();

    logic [1:0] s_arw_id, s_bid, s_rid;
    logic       id_err;

    logic [2:0]        req, wr_v, wvalid_v, wlast_v, bready_v, rready_v;
    logic [ADDR_W-1:0] addr_v [3];
    logic [7:0]        len_v [3];
    logic [31:0]       wdata_v [3];
    logic [3:0]        wstrb_v [3];
    logic [2:0]        arw_ready_o, wready_o, bvalid_o, rvalid_o, rlast_o;
    logic [31:0]       rdata_o [3];

    for (genvar g = 0; g < 3; g++) begin : g_port
        assign m_if[g].arw_valid = req[g];
        assign m_if[g].arw_addr  = addr_v[g];
        assign m_if[g].arw_len   = len_v[g];
        assign m_if[g].arw_write = wr_v[g];
        assign m_if[g].wvalid    = wvalid_v[g];
        assign m_if[g].wlast     = wlast_v[g];
        assign m_if[g].wdata     = wdata_v[g];
        assign m_if[g].wstrb     = wstrb_v[g];
        assign m_if[g].bready    = bready_v[g];
        assign m_if[g].rready    = rready_v[g];
        assign arw_ready_o[g]    = m_if[g].arw_ready;
        assign wready_o[g]       = m_if[g].wready;
        assign bvalid_o[g]       = m_if[g].bvalid;
        assign rvalid_o[g]       = m_if[g].rvalid;
        assign rlast_o[g]        = m_if[g].rlast;
        assign rdata_o[g]        = m_if[g].rdata;
    end

    ddr_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0       (m_if[0]),
        .m1       (m_if[1]),
        .m2       (m_if[2]),
        .s        (s_if),
        .s_arw_id (s_arw_id),
        .s_bid    (s_bid),
        .s_rid    (s_rid),
        .id_err   (id_err)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_win;
    logic exp_id_err;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req = '0; wr_v = '0; wvalid_v = '0; wlast_v = '0; bready_v = '0; rready_v = '0;
        for (int p = 0; p < 3; p++) begin
            addr_v[p] = '0; len_v[p] = '0; wdata_v[p] = '0; wstrb_v[p] = '0;
        end
        s_if.arw_ready = 0; s_if.wready = 0; s_if.bvalid = 0;
        s_if.rvalid = 0; s_if.rlast = 0; s_if.rdata = '0;
        s_bid = '0; s_rid = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        last_win   = 2;
        exp_id_err = 1'b0;
    endtask

    // Rotating priority: the search begins at the port after the last winner.
    function automatic int model_pick(input logic [2:0] mask);
        for (int k = 1; k <= 3; k++)
            if (mask[(last_win + k) % 3]) return (last_win + k) % 3;
        return -1;
    endfunction

    // Runs one full transaction against the controller model, starting in an IDLE cycle.
    task automatic do_txn(input logic [2:0] mask, input logic [2:0] late_mask,
                          input int early_last, input int force_id, output int w);
        int beats, exp_beats, guard, rid, d;
        logic [2:0] onehot;
        logic done;
        req = req | mask;
        w = model_pick(req);
        if (w < 0) begin
            n_tests++; n_fail++;
            $display("FAIL no_request: empty request mask");
            return;
        end
        onehot = 3'b001 << w;
        #3;
        n_tests++;
        if (arw_ready_o !== onehot) begin
            n_fail++; $display("FAIL grant: arw_ready=%b required %b", arw_ready_o, onehot);
        end
        tick();
        req[w] = 1'b0;
        req = req | late_mask;
        last_win = w;
        #3;
        n_tests++;
        if ({s_if.arw_valid, s_arw_id, s_if.arw_addr, s_if.arw_len, s_if.arw_write, arw_ready_o}
            !== {1'b1, 2'(w), addr_v[w], len_v[w], wr_v[w], 3'b000}) begin
            n_fail++;
            $display("FAIL addr_phase: valid=%b id=%0d addr=%h len=%0d wr=%b rdy=%b required 1 %0d %h %0d %b 000",
                     s_if.arw_valid, s_arw_id, s_if.arw_addr, s_if.arw_len, s_if.arw_write, arw_ready_o,
                     w, addr_v[w], len_v[w], wr_v[w]);
        end
        d = $urandom_range(0, 2);
        repeat (d) tick();
        s_if.arw_ready = 1'b1;
        tick();
        s_if.arw_ready = 1'b0;
        rid = (force_id >= 0) ? force_id : w;
        if (wr_v[w]) begin
            exp_beats = (early_last >= 0 && early_last < int'(len_v[w])) ? early_last + 1 : int'(len_v[w]) + 1;
            wvalid_v = 3'b111;
            beats = 0; guard = 0;
            while (beats < exp_beats && guard < 200) begin
                s_if.wready = 1'($urandom_range(0, 1));
                for (int p = 0; p < 3; p++) begin
                    wdata_v[p] = $urandom; wstrb_v[p] = 4'($urandom);
                end
                wlast_v = (early_last >= 0 && beats == exp_beats - 1) ? onehot : 3'b000;
                #3;
                n_tests++;
                if (wready_o !== (s_if.wready ? onehot : 3'b000) || arw_ready_o !== 3'b000 || s_if.wvalid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL w_route: wready=%b arw_ready=%b s_wvalid=%b required wready=%b arw_ready=000 s_wvalid=1",
                             wready_o, arw_ready_o, s_if.wvalid, s_if.wready ? onehot : 3'b000);
                end
                if (s_if.wready) begin
                    n_tests++;
                    if (s_if.wdata !== wdata_v[w] || s_if.wstrb !== wstrb_v[w] || s_if.wlast !== wlast_v[w]) begin
                        n_fail++;
                        $display("FAIL w_beat: data=%h strb=%h last=%b required %h %h %b",
                                 s_if.wdata, s_if.wstrb, s_if.wlast, wdata_v[w], wstrb_v[w], wlast_v[w]);
                    end
                    beats++;
                end
                tick();
                guard++;
            end
            wlast_v = 3'b000;
            s_if.wready = 1'b1;
            #3;
            n_tests++;
            if (beats != exp_beats || s_if.wvalid !== 1'b0 || wready_o !== 3'b000) begin
                n_fail++;
                $display("FAIL w_end: beats=%0d s_wvalid=%b wready=%b required beats=%0d s_wvalid=0 wready=000",
                         beats, s_if.wvalid, wready_o, exp_beats);
            end
            tick();
            s_if.wready = 1'b0;
            s_if.bvalid = 1'b1;
            s_bid = 2'(rid);
            guard = 0; done = 1'b0;
            while (!done && guard < 50) begin
                bready_v = 3'($urandom);
                #3;
                n_tests++;
                if (bvalid_o !== onehot || s_if.bready !== bready_v[w] || arw_ready_o !== 3'b000) begin
                    n_fail++;
                    $display("FAIL b_route: bvalid=%b s_bready=%b arw_ready=%b required %b %b 000",
                             bvalid_o, s_if.bready, arw_ready_o, onehot, bready_v[w]);
                end
                done = bready_v[w];
                tick();
                guard++;
            end
            if (!done) begin
                n_tests++; n_fail++;
                $display("FAIL b_timeout: no b handshake in %0d cycles, required one", guard);
            end
            s_if.bvalid = 1'b0; wvalid_v = '0; bready_v = '0;
        end else begin
            rready_v = 3'b111;
            for (int b = 0; b <= int'(len_v[w]); b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    s_if.rvalid = 1'b0;
                    #3;
                    n_tests++;
                    if (rvalid_o !== 3'b000) begin
                        n_fail++; $display("FAIL r_gap: rvalid=%b required 000", rvalid_o);
                    end
                    tick();
                end
                s_if.rvalid = 1'b1;
                s_if.rlast  = (b == int'(len_v[w]));
                s_if.rdata  = $urandom;
                s_rid       = 2'(rid);
                #3;
                n_tests++;
                if (rvalid_o !== onehot || rlast_o !== (s_if.rlast ? onehot : 3'b000) ||
                    rdata_o[w] !== s_if.rdata || s_if.rready !== 1'b1 || arw_ready_o !== 3'b000) begin
                    n_fail++;
                    $display("FAIL r_beat%0d: rvalid=%b rlast=%b rdata=%h rready=%b arw_ready=%b required %b %b %h 1 000",
                             b, rvalid_o, rlast_o, rdata_o[w], s_if.rready, arw_ready_o,
                             onehot, s_if.rlast ? onehot : 3'b000, s_if.rdata);
                end
                tick();
            end
            s_if.rvalid = 1'b0; s_if.rlast = 1'b0; rready_v = '0;
        end
        if (force_id >= 0 && force_id != w) exp_id_err = 1'b1;
        n_tests++;
        if (id_err !== exp_id_err || s_if.arw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL txn_end: id_err=%b s_arw_valid=%b required %b 0", id_err, s_if.arw_valid, exp_id_err);
        end
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        req = 3'b111; wvalid_v = 3'b111; bready_v = 3'b111; rready_v = 3'b111;
        s_if.arw_ready = 1; s_if.wready = 1; s_if.bvalid = 1; s_if.rvalid = 1; s_if.rlast = 1;
        tick(); tick();
        #3;
        n_tests++;
        if ({arw_ready_o, wready_o, bvalid_o, rvalid_o, s_if.arw_valid, s_if.wvalid, s_if.bready, s_if.rready, id_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: arw=%b w=%b b=%b r=%b s=%b%b%b%b id_err=%b required all 0",
                     arw_ready_o, wready_o, bvalid_o, rvalid_o, s_if.arw_valid, s_if.wvalid, s_if.bready, s_if.rready, id_err);
        end
        tick();
        clear_inputs();
        reset = 1'b0;
        last_win = 2; exp_id_err = 1'b0;
        tick();
        n_tests++;
        if (s_if.arw_valid !== 1'b0 || arw_ready_o !== 3'b000 || id_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: s_arw_valid=%b arw_ready=%b id_err=%b required 0 000 0", s_if.arw_valid, arw_ready_o, id_err);
        end
    endtask

    task automatic test_all_read;
        int w;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            wr_v[p] = 1'b0; len_v[p] = 8'd3; addr_v[p] = ADDR_W'($urandom);
        end
        do_txn(3'b111, 3'b000, -1, -1, w);
        do_txn(3'b000, 3'b000, -1, -1, w);
        do_txn(3'b000, 3'b000, -1, -1, w);
    endtask

    task automatic test_write_hold;
        int w;
        do_reset();
        wr_v[1] = 1'b1; len_v[1] = 8'd7; addr_v[1] = ADDR_W'($urandom);
        wr_v[0] = 1'b0; len_v[0] = 8'd0; addr_v[0] = ADDR_W'($urandom);
        do_txn(3'b010, 3'b001, -1, -1, w);
        do_txn(3'b000, 3'b000, -1, -1, w);
    endtask

    task automatic test_wlast_early;
        int w;
        do_reset();
        wr_v[2] = 1'b1; len_v[2] = 8'd7; addr_v[2] = ADDR_W'($urandom);
        do_txn(3'b100, 3'b000, 3, -1, w);
    endtask

    task automatic test_id_err;
        int w;
        do_reset();
        wr_v[1] = 1'b0; len_v[1] = 8'd1;
        do_txn(3'b010, 3'b000, -1, 2, w);
        wr_v[0] = 1'b1; len_v[0] = 8'd0;
        do_txn(3'b001, 3'b000, -1, -1, w);
        do_reset();
        n_tests++;
        if (id_err !== 1'b0) begin
            n_fail++; $display("FAIL id_err_clear: id_err=%b required 0", id_err);
        end
    endtask

    task automatic test_reset_mid;
        int w;
        do_reset();
        wr_v[1] = 1'b1; len_v[1] = 8'd7;
        req = 3'b010;
        tick();
        req = 3'b000;
        s_if.arw_ready = 1'b1;
        tick();
        s_if.arw_ready = 1'b0;
        wvalid_v = 3'b010; s_if.wready = 1'b1;
        tick(); tick();
        reset = 1'b1;
        s_if.bvalid = 1'b1; s_if.rvalid = 1'b1;
        #3;
        n_tests++;
        if ({arw_ready_o, wready_o, bvalid_o, rvalid_o, s_if.arw_valid, s_if.wvalid, s_if.bready, s_if.rready} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: arw=%b w=%b b=%b r=%b s=%b%b%b%b required all 0",
                     arw_ready_o, wready_o, bvalid_o, rvalid_o, s_if.arw_valid, s_if.wvalid, s_if.bready, s_if.rready);
        end
        tick();
        reset = 1'b0;
        s_if.bvalid = 1'b0; s_if.rvalid = 1'b0;
        #3;
        n_tests++;
        if (s_if.wvalid !== 1'b0 || wready_o !== 3'b000 || s_if.arw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: s_wvalid=%b wready=%b s_arw_valid=%b required 0 000 0", s_if.wvalid, wready_o, s_if.arw_valid);
        end
        wvalid_v = '0; s_if.wready = 1'b0;
        last_win = 2; exp_id_err = 1'b0;
        tick();
        wr_v = 3'b011; len_v[0] = 8'd1; len_v[1] = 8'd1; len_v[2] = 8'd0;
        do_txn(3'b111, 3'b000, -1, -1, w);
        do_txn(3'b000, 3'b000, -1, -1, w);
        do_txn(3'b000, 3'b000, -1, -1, w);
    endtask

    task automatic test_starve;
        int w;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            wr_v[p] = 1'b0; len_v[p] = 8'd0;
        end
        repeat (3) do_txn(3'b100, 3'b000, -1, -1, w);
        do_txn(3'b101, 3'b000, -1, -1, w);
        do_txn(3'b000, 3'b000, -1, -1, w);
    endtask

    task automatic test_random;
        int w, early;
        logic [2:0] mask;
        do_reset();
        for (int r = 0; r < 40; r++) begin
            for (int p = 0; p < 3; p++) begin
                addr_v[p] = ADDR_W'($urandom);
                len_v[p]  = 8'($urandom_range(0, 7));
                wr_v[p]   = 1'($urandom_range(0, 1));
            end
            mask = 3'($urandom_range(0, 7));
            if ((req | mask) == 3'b000) mask = 3'b001 << $urandom_range(0, 2);
            early = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
            do_txn(mask, 3'b000, early, -1, w);
        end
        while (req != 3'b000) do_txn(3'b000, 3'b000, -1, -1, w);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_all_read();
        test_write_hold();
        test_wlast_early();
        test_id_err();
        test_reset_mid();
        test_starve();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end
endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, byte-address width of every port (BA+ROW+COL+2).
REQ-002 SHALL have ports clk  input  1  system clock; reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide, for N in {0,1,2}: mN_arw_valid  in  1  request valid; mN_arw_ready  out  1  request accepted.
REQ-004 SHALL provide mN_arw_addr  in  ADDR_W  byte address; mN_arw_len  in  8  beats minus 1; mN_arw_write  in  1  1=write.
REQ-005 SHALL provide mN_wvalid  in  1; mN_wready  out  1; mN_wlast  in  1; mN_wdata  in  32; mN_wstrb  in  4.
REQ-006 SHALL provide mN_bvalid  out  1; mN_bready  in  1; mN_rvalid  out  1; mN_rready  in  1; mN_rlast  out  1; mN_rdata  out  32.
REQ-007 SHALL provide the downstream mirror s_arw_valid/ready/addr/len/write, s_arw_id  out  2, s_wvalid/wready/wlast/wdata/wstrb, s_bvalid/bready, s_bid  in  2, s_rvalid/rready/rlast/rdata, s_rid  in  2.
REQ-008 SHALL provide id_err  out  1  sticky flag: response ID did not match the granted port.

Function
REQ-009 SHALL implement an FSM with states IDLE, ADDR, WDATA, WRESP, RDATA; one transaction outstanding at a time.
REQ-010 IDLE: when any mN_arw_valid=1, SHALL pick a winner by round-robin, assert its mN_arw_ready combinationally that cycle, latch addr/len/write/index, and go to ADDR.
REQ-011 Round-robin: the port granted last SHALL have lowest priority next; after reset the priority order SHALL be 0>1>2.
REQ-012 ADDR: s_arw_valid=1 with the latched fields and s_arw_id=latched index; on s_arw_ready, go to WDATA if write, else RDATA. Request-to-s_arw_valid latency: 1 cycle.
REQ-013 WDATA: the granted port's w channel SHALL be wired combinationally to s_w*; every other mN_wready SHALL be 0; s_wvalid=0 when the granted port has none.
REQ-014 WDATA: an 8-bit beat counter SHALL count s_wvalid&&s_wready handshakes; on a handshake with counter==len or wlast=1, go to WRESP.
REQ-015 WRESP: s_bvalid SHALL route only to the granted mN_bvalid and its mN_bready to s_bready; on the handshake, go to IDLE.
REQ-016 RDATA: s_rvalid/rlast/rdata SHALL route to the granted port and its mN_rready to s_rready; on s_rvalid&&s_rlast, go to IDLE.
REQ-017 Ungranted mN_bvalid/mN_rvalid SHALL be 0 at all times; mN_rdata of all ports MAY carry s_rdata.
REQ-018 Downstream rvalid has no back-pressure; masters SHALL accept read beats every cycle, and the arbiter SHALL NOT buffer read data.
REQ-019 id_err SHALL set when s_bvalid (WRESP) or s_rvalid (RDATA) is seen with s_bid/s_rid != latched index, and stay set until reset.
REQ-020 A request arriving in the cycle its port's transaction returns to IDLE SHALL be eligible only from the next cycle (IDLE lasts at least 1 cycle).
REQ-021 mN_arw_valid deasserted before grant SHALL be ignored with no state effect; len=0 SHALL give a single-beat transaction.

Reset
REQ-022 On reset: state=IDLE, RR pointer such that port 0 wins, beat counter=0, latched index=0, id_err=0.
REQ-023 During reset all mN_arw_ready, mN_wready, mN_bvalid, mN_rvalid, s_arw_valid, s_wvalid, s_bready, s_rready SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon it immediately; the DDR controller SHALL be reset in the same cycle.

Verification
REQ-025 Ports 0,1,2 all request reads (len=3) in the same cycle after reset -> grants in order 0,1,2; each gets exactly 4 rvalid beats, last with rlast; s_arw_id=0,1,2.
REQ-026 Port 1 writes len=7 while port 0 holds arw_valid -> port 0 mN_wready stays 0; 8 beats forwarded; port 0 granted only after port 1's b handshake.
REQ-027 Write len=7 with wlast on beat 3 -> WRESP after 4 beats; bvalid only on the writer's port.
REQ-028 Controller returns s_rid=2 while port 1 is granted -> id_err=1, held until reset.
REQ-029 Reset asserted in WDATA after 2 beats -> next cycle all handshake outputs 0, state IDLE, port 0 highest priority.
REQ-030 Port 2 alone requests continuously for 3 transactions, then port 0 joins -> port 0 granted on the next arbitration.
